nonce_scheduler: RTL

Controller that sequences the SHA-256 round datapath across a range of nonces. It drives the 6-bit round counter and the current nonce into the hash core and the zero-hash checker. It evaluates the first 32 bits of each finished hash and reports the first qualifying nonce through a held result/acknowledge handshake. It sits between the host command interface (start/abort, range registers) and the hash core.

---
 rtl/miner_pkg.sv | 13 +
 rtl/round_counter.sv | 26 ++
 rtl/nonce_scheduler.sv | 113 +++++++++++
 3 files changed

// File: rtl/miner_pkg.sv
// Shared types and constants for the nonce search controller and its round counter.
package miner_pkg;
    localparam int NONCE_W = 32;
    localparam logic [5:0] ROUND_LAST = 6'd63;

    typedef enum logic [2:0] {
        IDLE,
        HASH,
        CHECK,
        FOUND,
        DONE
    } sched_state_t;
endpackage

// File: rtl/round_counter.sv
// 6-bit round index with synchronous clear and enable; wraps to 0 after LAST.
// One-cycle update latency; last is decoded from the registered count.
module round_counter
    import miner_pkg::*;
#(
    parameter logic [5:0] LAST = ROUND_LAST
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr,
    input  logic       en,
    output logic [5:0] count,
    output logic       last
);
    assign last = (count == LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= 6'd0;
        end else if (clr) begin
            count <= 6'd0;
        end else if (en) begin
            count <= last ? 6'd0 : count + 6'd1;
        end
    end
endmodule

// File: rtl/nonce_scheduler.sv
// Sequences hash rounds over an inclusive nonce range and reports the first zero hash.
// Start to HASH in one edge; 65 cycles per nonce; FOUND holds until result_ack, abort overrides all.
module nonce_scheduler
    import miner_pkg::*;
#(
    parameter int ROUNDS = 64
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    input  logic [NONCE_W-1:0] hash_word,
    input  logic               result_ack,
    output logic [5:0]         count,
    output logic [NONCE_W-1:0] nonce,
    output logic               found,
    output logic [NONCE_W-1:0] found_nonce,
    output logic               exhausted,
    output logic               busy,
    output logic [NONCE_W-1:0] hash_count
);
    localparam logic [5:0] LAST = 6'(ROUNDS - 1);

    sched_state_t       state;
    logic [NONCE_W-1:0] end_reg;
    logic               cnt_clr;
    logic               cnt_en;
    logic               cnt_last;
    logic               start_ok;
    logic               at_end;

    assign start_ok = start && (state == IDLE || state == DONE);
    assign cnt_clr  = abort || start_ok;
    assign cnt_en   = (state == HASH);
    assign at_end   = (nonce == end_reg);

    round_counter #(.LAST(LAST)) u_round_counter (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (count),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            nonce       <= '0;
            end_reg     <= '0;
            found_nonce <= '0;
            hash_count  <= '0;
            found       <= 1'b0;
            exhausted   <= 1'b0;
            busy        <= 1'b0;
        end else if (abort) begin
            // nonce, found_nonce and hash_count stay visible for post-mortem
            state     <= IDLE;
            found     <= 1'b0;
            exhausted <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        nonce      <= nonce_start;
                        end_reg    <= nonce_end;
                        hash_count <= '0;
                        exhausted  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= HASH;
                    end
                end
                HASH: begin
                    if (cnt_last) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    hash_count <= hash_count + 1'b1;
                    if (hash_word == '0) begin
                        found_nonce <= nonce;
                        found       <= 1'b1;
                        state       <= FOUND;
                    end else if (at_end) begin
                        busy      <= 1'b0;
                        exhausted <= 1'b1;
                        state     <= DONE;
                    end else begin
                        nonce <= nonce + 1'b1;
                        state <= HASH;
                    end
                end
                FOUND: begin
                    if (result_ack) begin
                        found <= 1'b0;
                        if (at_end) begin
                            busy      <= 1'b0;
                            exhausted <= 1'b1;
                            state     <= DONE;
                        end else begin
                            nonce <= nonce + 1'b1;
                            state <= HASH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
